// File: rtl/icache_pkg.sv
// Shared definitions for the N-way instruction cache.
//   state_t    : controller states (IDLE=0, MISS=1, FLUSH=2)
//   offset_w   : word-offset field width for a given line size
//   index_w    : set-index field width for a given set count
//   tag_w      : tag field width for a given address/set/line geometry
//   ptr_w      : round-robin pointer width (1 bit minimum so a signal exists)
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MISS  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic int unsigned offset_w(input int unsigned words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int unsigned index_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned sets,
                                        input int unsigned words_per_line);
    return addr_w - $clog2(sets) - $clog2(words_per_line);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_nway_if.sv
// Fetch-port and line-memory handshake bundle for icache_nway.
//   Fetch side : read_enable, address (to cache); read_ready, instruction,
//                busy (from cache)
//   Memory side: memory_read_enable, memory_address (from cache);
//                memory_read_ready, memory_data (to cache)
//   slave  modport: the cache's view
//   master modport: the processor/memory environment's view
interface icache_nway_if #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned WORD_W         = 16,
  parameter int unsigned WORDS_PER_LINE = 4
);
  localparam int unsigned LINE_ADDR_W = ADDR_W - icache_pkg::offset_w(WORDS_PER_LINE);
  localparam int unsigned LINE_W      = WORD_W * WORDS_PER_LINE;

  logic                   read_enable;
  logic [ADDR_W-1:0]      address;
  logic                   read_ready;
  logic [WORD_W-1:0]      instruction;
  logic                   busy;
  logic                   memory_read_enable;
  logic [LINE_ADDR_W-1:0] memory_address;
  logic                   memory_read_ready;
  logic [LINE_W-1:0]      memory_data;

  modport slave (
    input  read_enable, address, memory_read_ready, memory_data,
    output read_ready, instruction, busy, memory_read_enable, memory_address
  );

  modport master (
    output read_enable, address, memory_read_ready, memory_data,
    input  read_ready, instruction, busy, memory_read_enable, memory_address
  );

endinterface

// File: rtl/icache_victim_sel.sv
// Replacement-way chooser for one set.
//   valid    : per-way valid bits of the set being filled
//   ptr      : the set's round-robin pointer
//   victim   : lowest-index invalid way, else ptr
//   next_ptr : ptr+1 (mod WAYS) when the pointer was used, else ptr unchanged
module icache_victim_sel
  import icache_pkg::*;
#(
  parameter  int unsigned WAYS  = 2,
  localparam int unsigned PTR_W = ptr_w(WAYS)
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] victim,
  output logic [PTR_W-1:0] next_ptr
);

  logic found;

  always_comb begin
    found    = 1'b0;
    victim   = ptr;
    next_ptr = ptr;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && !valid[w]) begin
        found  = 1'b1;
        victim = PTR_W'(w);
      end
    end
    // WAYS is a power of two, so the natural PTR_W-bit wrap is the modulo.
    if (!found && WAYS > 1) next_ptr = ptr + 1'b1;
  end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache.
//   clock, reset : clock; synchronous active-high reset
//   flush        : invalidate every line (sampled in IDLE only, beats reads)
//   bus          : fetch and line-memory handshakes (icache_nway_if.slave)
//   hit_count    : saturating hit counter
//   miss_count   : saturating miss counter
// Hits return one cycle after the request. Misses capture the address, fetch
// the whole line, fill the victim way and forward the requested word straight
// from memory_data. A flush walks one set per cycle for SETS cycles.
module icache_nway
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned WORD_W         = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned SETS           = 8,
  parameter int unsigned WAYS           = 2,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  icache_nway_if.slave     bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned OFF_W  = offset_w(WORDS_PER_LINE);
  localparam int unsigned IDX_W  = index_w(SETS);
  localparam int unsigned TAG_W  = tag_w(ADDR_W, SETS, WORDS_PER_LINE);
  localparam int unsigned PTR_W  = ptr_w(WAYS);
  localparam int unsigned LINE_W = WORD_W * WORDS_PER_LINE;

  // Storage
  logic [WAYS-1:0]   valid_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];

  // Controller state and registered outputs
  state_t            state;
  logic [ADDR_W-1:0] req_addr;
  logic [IDX_W-1:0]  flush_idx;
  logic              read_ready_q;
  logic [WORD_W-1:0] instruction_q;
  logic              busy_q;
  logic              mem_re_q;

  // Address fields of the incoming request and of the captured miss
  logic [TAG_W-1:0] in_tag,  req_tag;
  logic [IDX_W-1:0] in_idx,  req_idx;
  logic [OFF_W-1:0] in_off,  req_off;

  assign in_tag  = bus.address[ADDR_W-1 -: TAG_W];
  assign in_idx  = bus.address[OFF_W +: IDX_W];
  assign in_off  = bus.address[OFF_W-1:0];
  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign req_off = req_addr[OFF_W-1:0];

  function automatic logic [WORD_W-1:0] word_of(input logic [LINE_W-1:0] line,
                                                input logic [OFF_W-1:0]  off);
    return line[off*WORD_W +: WORD_W];
  endfunction

  // Hit detection; lowest matching way wins should two ever match.
  logic             hit;
  logic [PTR_W-1:0] hit_way;
  logic [WORD_W-1:0] hit_word;
  logic [WORD_W-1:0] fill_word;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[in_idx][w] && (tag_q[in_idx][w] == in_tag)) begin
        hit     = 1'b1;
        hit_way = PTR_W'(w);
      end
    end
  end

  assign hit_word  = word_of(data_q[in_idx][hit_way], in_off);
  assign fill_word = word_of(bus.memory_data, req_off);

  // Replacement
  logic             fill_fire;
  logic             flush_step;
  logic [PTR_W-1:0] ptr_cur;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W-1:0] victim;

  assign fill_fire  = (state == ST_MISS) && bus.memory_read_ready;
  assign flush_step = (state == ST_FLUSH);

  icache_victim_sel #(.WAYS(WAYS)) u_victim_sel (
    .valid    (valid_q[req_idx]),
    .ptr      (ptr_cur),
    .victim   (victim),
    .next_ptr (ptr_next)
  );

  generate
    if (WAYS > 1) begin : g_rr
      logic [PTR_W-1:0] ptr_q [SETS];

      always_ff @(posedge clock) begin
        if (reset) begin
          for (int unsigned s = 0; s < SETS; s++) ptr_q[s] <= '0;
        end else if (flush_step) begin
          ptr_q[flush_idx] <= '0;
        end else if (fill_fire) begin
          ptr_q[req_idx] <= ptr_next;
        end
      end

      assign ptr_cur = ptr_q[req_idx];
    end else begin : g_dm
      assign ptr_cur = '0;
    end
  endgenerate

  // Tag/data arrays carry no reset; valid bits alone define contents.
  always_ff @(posedge clock) begin
    if (!reset && fill_fire) begin
      tag_q[req_idx][victim]  <= req_tag;
      data_q[req_idx][victim] <= bus.memory_data;
    end
  end

  // Controller
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      req_addr      <= '0;
      flush_idx     <= '0;
      read_ready_q  <= 1'b0;
      instruction_q <= '0;
      busy_q        <= 1'b0;
      mem_re_q      <= 1'b0;
      hit_count     <= '0;
      miss_count    <= '0;
      for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      read_ready_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (flush) begin
            state     <= ST_FLUSH;
            flush_idx <= '0;
            busy_q    <= 1'b1;
          end else if (bus.read_enable) begin
            if (hit) begin
              read_ready_q  <= 1'b1;
              instruction_q <= hit_word;
              if (hit_count != '1) hit_count <= hit_count + 1'b1;
            end else begin
              req_addr <= bus.address;
              state    <= ST_MISS;
              busy_q   <= 1'b1;
              mem_re_q <= 1'b1;
            end
          end
        end
        ST_MISS: begin
          if (bus.memory_read_ready) begin
            valid_q[req_idx][victim] <= 1'b1;
            read_ready_q  <= 1'b1;
            instruction_q <= fill_word;
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
            mem_re_q <= 1'b0;
          end
        end
        ST_FLUSH: begin
          valid_q[flush_idx] <= '0;
          if (flush_idx == IDX_W'(SETS - 1)) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            flush_idx <= flush_idx + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          busy_q   <= 1'b0;
          mem_re_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.read_ready         = read_ready_q;
  assign bus.instruction        = instruction_q;
  assign bus.busy               = busy_q;
  assign bus.memory_read_enable = mem_re_q;
  assign bus.memory_address     = req_addr[ADDR_W-1:OFF_W];

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway (2 ways, 8 sets, 4-word lines, 4-bit
// counters so saturation is reachable).
module tb_icache_nway;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned WPL    = 4;
  localparam int unsigned SETS   = 8;
  localparam int unsigned WAYS   = 2;
  localparam int unsigned CNT_W  = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  icache_nway_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .WORDS_PER_LINE(WPL)) bus ();

  icache_nway #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .WORDS_PER_LINE(WPL),
    .SETS(SETS), .WAYS(WAYS), .CNT_W(CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  localparam logic [63:0] L1 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] LA = 64'hA003_A002_A001_A000;
  localparam logic [63:0] LB = 64'hB003_B002_B001_B000;
  localparam logic [63:0] LC = 64'hC003_C002_C001_C000;
  localparam logic [63:0] LD = 64'hD3D3_D2D2_D1D1_D0D0;
  localparam logic [63:0] LE = 64'hE003_E002_E001_E000;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [ADDR_W-1:0] a);
    bus.read_enable = 1'b1;
    bus.address     = a;
    tick();
    bus.read_enable = 1'b0;
  endtask

  task automatic serve(input logic [63:0] line);
    int unsigned n = 0;
    while (!bus.memory_read_enable && n < 20) begin
      tick();
      n++;
    end
    chk("mem_req_seen", bus.memory_read_enable, 1);
    bus.memory_data       = line;
    bus.memory_read_ready = 1'b1;
    tick();
    bus.memory_read_ready = 1'b0;
  endtask

  task automatic miss_fill(input string tag, input logic [ADDR_W-1:0] a,
                           input logic [63:0] line, input logic [15:0] word,
                           input logic [CNT_W-1:0] misses);
    request(a);
    chk({tag, "_busy"}, bus.busy, 1);
    chk({tag, "_maddr"}, bus.memory_address, a >> 2);
    serve(line);
    chk({tag, "_rr"}, bus.read_ready, 1);
    chk({tag, "_instr"}, bus.instruction, word);
    chk({tag, "_misses"}, miss_count, misses);
  endtask

  initial begin
    int unsigned n;
    bus.read_enable       = 1'b0;
    bus.address           = '0;
    bus.memory_read_ready = 1'b0;
    bus.memory_data       = '0;
    flush                 = 1'b0;
    reset                 = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_rr", bus.read_ready, 0);
    chk("rst_instr", bus.instruction, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mre", bus.memory_read_enable, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);

    // First miss: 0x23 -> line 0x08, word 3
    request(8'h23);
    chk("m1_busy", bus.busy, 1);
    chk("m1_mre", bus.memory_read_enable, 1);
    chk("m1_maddr", bus.memory_address, 6'h08);
    chk("m1_rr_early", bus.read_ready, 0);
    serve(L1);
    chk("m1_rr", bus.read_ready, 1);
    chk("m1_instr", bus.instruction, 16'h4444);
    chk("m1_misses", miss_count, 1);
    chk("m1_mre_off", bus.memory_read_enable, 0);
    chk("m1_busy_off", bus.busy, 0);
    tick();
    chk("m1_rr_pulse", bus.read_ready, 0);
    chk("m1_instr_hold", bus.instruction, 16'h4444);

    // Back-to-back hits
    bus.read_enable = 1'b1;
    bus.address = 8'h20; tick();
    chk("h0_rr", bus.read_ready, 1); chk("h0_instr", bus.instruction, 16'h1111);
    chk("h0_mre", bus.memory_read_enable, 0);
    bus.address = 8'h21; tick();
    chk("h1_rr", bus.read_ready, 1); chk("h1_instr", bus.instruction, 16'h2222);
    chk("h1_mre", bus.memory_read_enable, 0);
    bus.address = 8'h22; tick();
    chk("h2_rr", bus.read_ready, 1); chk("h2_instr", bus.instruction, 16'h3333);
    chk("h2_mre", bus.memory_read_enable, 0);
    bus.read_enable = 1'b0;
    chk("h_hits", hit_count, 3);

    // Three lines into set 2: third evicts way 0 (0x08)
    miss_fill("fa", 8'h08, LA, 16'hA000, 2);
    miss_fill("fb", 8'h28, LB, 16'hB000, 3);
    miss_fill("fc", 8'h48, LC, 16'hC000, 4);
    request(8'h28);
    chk("rb_rr", bus.read_ready, 1);
    chk("rb_instr", bus.instruction, 16'hB000);
    chk("rb_busy", bus.busy, 0);
    chk("rb_hits", hit_count, 4);
    miss_fill("ra", 8'h08, LA, 16'hA000, 5);
    request(8'h48);
    chk("rc_rr", bus.read_ready, 1);
    chk("rc_instr", bus.instruction, 16'hC000);
    chk("rc_hits", hit_count, 5);

    // Long miss with address churn
    request(8'h37);
    for (int i = 0; i < 10; i++) begin
      bus.address     = 8'(i * 17 + 3);
      bus.read_enable = i[0];
      tick();
      chk("stall_maddr", bus.memory_address, 6'h0D);
      chk("stall_busy", bus.busy, 1);
    end
    bus.read_enable = 1'b0;
    serve(LD);
    chk("stall_rr", bus.read_ready, 1);
    chk("stall_instr", bus.instruction, 16'hD3D3);
    chk("stall_misses", miss_count, 6);
    request(8'h34);
    chk("stall_hit_rr", bus.read_ready, 1);
    chk("stall_hit_instr", bus.instruction, 16'hD0D0);
    chk("stall_hits", hit_count, 6);

    // Flush wins over a simultaneous hit and lasts SETS cycles
    flush = 1'b1;
    bus.read_enable = 1'b1;
    bus.address = 8'h20;
    tick();
    flush = 1'b0;
    bus.read_enable = 1'b0;
    chk("fl_no_rr", bus.read_ready, 0);
    n = 0;
    while (bus.busy && n < 20) begin
      n++;
      tick();
    end
    chk("fl_cycles", n, 8);
    chk("fl_hits", hit_count, 6);
    miss_fill("pf0", 8'h20, L1, 16'h1111, 7);
    miss_fill("pf2", 8'h08, LA, 16'hA000, 8);
    miss_fill("pf5", 8'h34, LD, 16'hD0D0, 9);

    // Reset mid-miss, then a stale memory response
    request(8'h10);
    chk("rm_busy", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_busy_off", bus.busy, 0);
    chk("rm_mre_off", bus.memory_read_enable, 0);
    chk("rm_misses", miss_count, 0);
    chk("rm_hits", hit_count, 0);
    bus.memory_data       = LE;
    bus.memory_read_ready = 1'b1;
    tick();
    bus.memory_read_ready = 1'b0;
    chk("rm_no_rr", bus.read_ready, 0);
    chk("rm_no_busy", bus.busy, 0);
    chk("rm_no_miss", miss_count, 0);
    miss_fill("rm_f20", 8'h20, L1, 16'h1111, 1);
    miss_fill("rm_f10", 8'h10, LE, 16'hE000, 2);

    // Hit counter saturates at all-ones
    bus.read_enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.address = 8'h20 + 8'(i % 4);
      tick();
    end
    bus.read_enable = 1'b0;
    chk("sat_hits", hit_count, 4'hF);
    chk("sat_misses", miss_count, 2);
    chk("sat_last_instr", bus.instruction, 16'h4444);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
